// File: rtl/gate_mode_sequencer_pkg.sv
// Shared definitions for the gate-mode sequencer.
// Holds the mode encodings, the mode width and the pure gate-evaluation function.
package gate_mode_sequencer_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_AND  = 3'd0;
    localparam mode_t MODE_OR   = 3'd1;
    localparam mode_t MODE_NAND = 3'd2;
    localparam mode_t MODE_NOR  = 3'd3;
    localparam mode_t MODE_XOR  = 3'd4;
    localparam mode_t MODE_XNOR = 3'd5;
    localparam mode_t MODE_LAST = MODE_XNOR;

    // Codes 6 and 7 evaluate to 0 so a corrupted mode can never light LED_1.
    function automatic logic gate_eval(
        input logic  a,
        input logic  b,
        input mode_t mode
    );
        logic r;
        case (mode)
            MODE_AND:  r = a & b;
            MODE_OR:   r = a | b;
            MODE_NAND: r = ~(a & b);
            MODE_NOR:  r = ~(a | b);
            MODE_XOR:  r = a ^ b;
            MODE_XNOR: r = ~(a ^ b);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_mode_sequencer_debounce.sv
// Two-flop synchroniser plus stability counter for one raw board switch.
// Ports: i_Clk, i_Rst_n (async active-low), i_Raw (async input), o_Stable (debounced level).
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Raw,
    output logic o_Stable
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = i_Raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // Any sample matching the accepted level restarts the count,
        // so a glitch must be fully stable for the whole window to pass.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_Stable = stable_q;

endmodule

// File: rtl/gate_mode_sequencer.sv
// Top-level gate-mode sequencer: debounces four switches, steps the gate mode
// by button or auto-scan timer, drives the registered gate result and mode LEDs.
// Ports: i_Clk, i_Rst_n, i_Switch_1..4 (raw), o_LED_1 (result), o_LED_2..4 (mode bits 0..2).
module gate_mode_sequencer
    import gate_mode_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int AUTO_PERIOD     = 24000000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    input  logic i_Switch_3,
    input  logic i_Switch_4,
    output logic o_LED_1,
    output logic o_LED_2,
    output logic o_LED_3,
    output logic o_LED_4
);

    localparam int TW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);

    logic s1, s2, s3, s4;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_1 (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Raw    (i_Switch_1),
        .o_Stable (s1)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_2 (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Raw    (i_Switch_2),
        .o_Stable (s2)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_3 (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Raw    (i_Switch_3),
        .o_Stable (s3)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_4 (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Raw    (i_Switch_4),
        .o_Stable (s4)
    );

    logic          s3_prev_q, s3_prev_d;
    logic [TW-1:0] timer_q, timer_d;
    mode_t         mode_q, mode_d;
    logic          led1_q, led1_d;

    logic manual_step;
    logic auto_tick;
    logic step;

    // Rising edge only; s3_prev_q resets to 0, and s3 does too, so
    // releasing reset can never fabricate an edge.
    assign manual_step = s3 & ~s3_prev_q;
    assign auto_tick   = s4 & (timer_q == TIMER_LAST);
    assign step        = manual_step | auto_tick;

    always_comb begin
        s3_prev_d = s3;
        timer_d   = '0;
        if (s4 && !manual_step && (timer_q != TIMER_LAST)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_q > MODE_LAST) begin
            mode_d = MODE_AND;
        end else if (step) begin
            mode_d = (mode_q == MODE_LAST) ? MODE_AND : mode_q + 1'b1;
        end
        led1_d = gate_eval(s1, s2, mode_q);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            s3_prev_q <= 1'b0;
            timer_q   <= '0;
            mode_q    <= MODE_AND;
            led1_q    <= 1'b0;
        end else begin
            s3_prev_q <= s3_prev_d;
            timer_q   <= timer_d;
            mode_q    <= mode_d;
            led1_q    <= led1_d;
        end
    end

    assign o_LED_1 = led1_q;
    assign o_LED_2 = mode_q[0];
    assign o_LED_3 = mode_q[1];
    assign o_LED_4 = mode_q[2];

endmodule

// File: tb/tb_gate_mode_sequencer.sv
// Directed self-checking bench for gate_mode_sequencer.
// Small debounce window and auto period keep every step short.
module tb_gate_mode_sequencer;

    logic clk;
    logic rst_n;
    logic sw1, sw2, sw3, sw4;
    logic led1, led2, led3, led4;

    int n_cmp;
    int n_err;

    gate_mode_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .AUTO_PERIOD     (10)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Switch_1 (sw1),
        .i_Switch_2 (sw2),
        .i_Switch_3 (sw3),
        .i_Switch_4 (sw4),
        .o_LED_1    (led1),
        .o_LED_2    (led2),
        .o_LED_3    (led3),
        .o_LED_4    (led4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] mode_now();
        return {led4, led3, led2};
    endfunction

    logic [2:0] exp_mode [6];
    logic       exp_led  [6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_mode = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        exp_led  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset with every switch high
        rst_n = 1'b0;
        sw1 = 1'b1; sw2 = 1'b1; sw3 = 1'b1; sw4 = 1'b1;
        cyc(3);
        chk("reset_leds", {led4, led3, led2, led1}, 4'b0000);
        sw3 = 1'b0; sw4 = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(6);
        chk("and_latency_early", {3'b000, led1}, 4'd0);
        cyc(1);
        chk("and_latency_hit", {3'b000, led1}, 4'd1);
        chk("mode_after_reset", {1'b0, mode_now()}, 4'd0);

        // Short glitch rejected, long change accepted
        sw1 = 1'b0;
        cyc(3);
        sw1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("glitch_reject", {3'b000, led1}, 4'd1);
        end
        sw1 = 1'b0;
        cyc(6);
        chk("debounce_early", {3'b000, led1}, 4'd1);
        cyc(1);
        chk("debounce_accept", {3'b000, led1}, 4'd0);

        // Manual cycling with A=1, B=0
        sw1 = 1'b1; sw2 = 1'b0;
        cyc(8);
        chk("and_1_0", {3'b000, led1}, 4'd0);
        sw3 = 1'b1;
        cyc(6);
        chk("press_early", {1'b0, mode_now()}, 4'd0);
        cyc(1);
        chk("press_mode", {1'b0, mode_now()}, 4'd1);
        chk("press_led_lag", {3'b000, led1}, 4'd0);
        cyc(1);
        chk("press_led_new", {3'b000, led1}, 4'd1);
        sw3 = 1'b0;
        cyc(8);
        for (int i = 1; i < 6; i++) begin
            sw3 = 1'b1;
            cyc(8);
            chk($sformatf("cycle_mode_%0d", i), {1'b0, mode_now()}, {1'b0, exp_mode[i]});
            chk($sformatf("cycle_led_%0d", i), {3'b000, led1}, {3'b000, exp_led[i]});
            sw3 = 1'b0;
            cyc(8);
        end

        // Long hold yields one step
        sw3 = 1'b1;
        cyc(100);
        chk("hold_one_step", {1'b0, mode_now()}, 4'd1);
        sw3 = 1'b0;
        cyc(8);
        chk("release_no_step", {1'b0, mode_now()}, 4'd1);

        // Auto scan: first tick 2+4+10 edges after enabling
        sw4 = 1'b1;
        cyc(15);
        chk("auto_first_early", {1'b0, mode_now()}, 4'd1);
        cyc(1);
        chk("auto_first", {1'b0, mode_now()}, 4'd2);
        cyc(10);
        chk("auto_3", {1'b0, mode_now()}, 4'd3);
        cyc(10);
        chk("auto_4", {1'b0, mode_now()}, 4'd4);
        cyc(10);
        chk("auto_5", {1'b0, mode_now()}, 4'd5);
        cyc(9);
        chk("auto_wrap_early", {1'b0, mode_now()}, 4'd5);
        cyc(1);
        chk("auto_wrap", {1'b0, mode_now()}, 4'd0);
        cyc(10);
        chk("auto_1", {1'b0, mode_now()}, 4'd1);

        // Disable: mode frozen, timer cleared
        sw4 = 1'b0;
        cyc(30);
        chk("auto_frozen", {1'b0, mode_now()}, 4'd1);
        sw4 = 1'b1;
        cyc(15);
        chk("timer_cleared_early", {1'b0, mode_now()}, 4'd1);
        cyc(1);
        chk("timer_cleared_tick", {1'b0, mode_now()}, 4'd2);

        // Manual edge coincides with terminal count
        cyc(3);
        sw3 = 1'b1;
        cyc(7);
        chk("simul_single_step", {1'b0, mode_now()}, 4'd3);
        cyc(9);
        chk("simul_next_early", {1'b0, mode_now()}, 4'd3);
        cyc(1);
        chk("simul_next_tick", {1'b0, mode_now()}, 4'd4);
        sw3 = 1'b0;

        // Asynchronous reset mid-operation, debounce in progress
        sw1 = 1'b0;
        cyc(3);
        chk("pre_reset_mode", {1'b0, mode_now()}, 4'd4);
        chk("pre_reset_led1", {3'b000, led1}, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_leds", {led4, led3, led2, led1}, 4'b0000);
        sw1 = 1'b1; sw2 = 1'b1; sw3 = 1'b0; sw4 = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(15);
        chk("post_reset_no_step", {1'b0, mode_now()}, 4'd0);
        chk("post_reset_led1", {3'b000, led1}, 4'd1);
        cyc(1);
        chk("post_reset_first_tick", {1'b0, mode_now()}, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
